// File: rtl/counters_pkg.sv
// Shared definitions for the up/down counter and its checker.
// Holds the checker state encoding and the single next-value function used by
// both the counter and the checker's reference model.
package counters_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    // One counter step on a 32-bit carrier; callers truncate to their own
    // width, which yields the modulo-2^WIDTH wrap for free.
    function automatic logic [31:0] next_count(input logic [31:0] val,
                                               input logic        en,
                                               input logic        dir);
        logic [31:0] nxt;
        nxt = val;
        if (en) begin
            if (dir) nxt = val + 32'd1;
            else     nxt = val - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/updown_count_checker_if.sv
// Bundle between the observed counter and its checker.
// master: side that drives the observed counter signals (counter/harness).
// slave : the checker, which only samples them and reports its results.
//   enable, countUpDown, count, clear : observed controls/value and stats clear
//   synced, expected, mismatch, err_sticky, err_count, wrap_up, wrap_down : results
interface updown_count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 enable;
    logic                 countUpDown;
    logic [WIDTH-1:0]     count;
    logic                 clear;
    logic                 synced;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 wrap_up;
    logic                 wrap_down;

    modport master (
        output enable, countUpDown, count, clear,
        input  synced, expected, mismatch, err_sticky, err_count, wrap_up, wrap_down
    );

    modport slave (
        input  enable, countUpDown, count, clear,
        output synced, expected, mismatch, err_sticky, err_count, wrap_up, wrap_down
    );
endinterface

// File: rtl/updown_count_checker_sat_counter.sv
// Saturating incrementer with synchronous clear, used as the error counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : add one unless already at all-ones
//   cnt        : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/updown_count_checker.sv
// Passive monitor for the up/down counter. Samples the counter controls and
// count each rising edge, predicts the next value and flags deviations.
//   clk, rst_n : system clock, asynchronous active-low reset (shared with counter)
//   mon        : slave view of the checker bundle (observed signals in,
//                synced/expected/mismatch/err_sticky/err_count/wrap_* out)
module updown_count_checker
    import counters_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int ERR_CNT_W       = 8,
    parameter bit CHECK_RESET_VAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    updown_count_checker_if.slave mon
);
    state_t           state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic             prev_dir;
    logic [WIDTH-1:0] exp_c;
    logic             mis_event;
    logic             wrap_up_ev;
    logic             wrap_down_ev;
    logic             mismatch_q;
    logic             sticky_q;
    logic             wrap_up_q;
    logic             wrap_down_q;

    // Prediction for the sample at the coming edge; meaningless before the
    // first sample, so it is forced to zero while unsynchronised.
    always_comb begin
        exp_c = '0;
        if (state != UNSYNC) begin
            exp_c = WIDTH'(next_count(32'(prev_count), prev_en, prev_dir));
        end
    end

    always_comb begin
        mis_event = 1'b0;
        case (state)
            UNSYNC:  mis_event = CHECK_RESET_VAL && (mon.count != '0);
            TRACK:   mis_event = (mon.count != exp_c);
            default: mis_event = 1'b0;
        endcase
    end

    // Wraps are only credited on a verified (matching) transition.
    always_comb begin
        wrap_up_ev   = (state == TRACK) && (mon.count == exp_c) && prev_en &&
                       prev_dir && (prev_count == '1) && (mon.count == '0);
        wrap_down_ev = (state == TRACK) && (mon.count == exp_c) && prev_en &&
                       !prev_dir && (prev_count == '0) && (mon.count == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UNSYNC;
            prev_count  <= '0;
            prev_en     <= 1'b0;
            prev_dir    <= 1'b0;
            mismatch_q  <= 1'b0;
            sticky_q    <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
        end else begin
            // Model always follows the observed counter, even after an error.
            prev_count <= mon.count;
            prev_en    <= mon.enable;
            prev_dir   <= mon.countUpDown;
            if (mon.clear) begin
                state       <= UNSYNC;
                mismatch_q  <= 1'b0;
                sticky_q    <= 1'b0;
                wrap_up_q   <= 1'b0;
                wrap_down_q <= 1'b0;
            end else begin
                mismatch_q  <= mis_event;
                wrap_up_q   <= wrap_up_ev;
                wrap_down_q <= wrap_down_ev;
                if (mis_event) sticky_q <= 1'b1;
                case (state)
                    UNSYNC:  state <= TRACK;
                    TRACK:   state <= mis_event ? RESYNC : TRACK;
                    RESYNC:  state <= TRACK;
                    default: state <= UNSYNC;
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mon.clear),
        .inc   (mis_event),
        .cnt   (mon.err_count)
    );

    assign mon.synced     = (state == TRACK);
    assign mon.expected   = exp_c;
    assign mon.mismatch   = mismatch_q;
    assign mon.err_sticky = sticky_q;
    assign mon.wrap_up    = wrap_up_q;
    assign mon.wrap_down  = wrap_down_q;

endmodule

// File: tb/tb_updown_count_checker.sv
// Bench for updown_count_checker: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the checking rules.
module tb_updown_count_checker;
    localparam int WIDTH     = 4;
    localparam int ERR_CNT_W = 2;
    localparam int MOD       = 1 << WIDTH;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk;
    logic rst_n;

    updown_count_checker_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) ifc ();

    updown_count_checker #(
        .WIDTH           (WIDTH),
        .ERR_CNT_W       (ERR_CNT_W),
        .CHECK_RESET_VAL (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: "have we seen a first sample", "is the next sample
    // skipped", last sampled value/controls, and the statistics.
    bit m_seen, m_skip;
    int m_pc;
    bit m_pe, m_pd;
    bit m_mis, m_sticky, m_wu, m_wd;
    int m_err;

    function automatic int predict(input int pc, input bit pe, input bit pd);
        if (!pe) return pc;
        return pd ? (pc + 1) % MOD : (pc + MOD - 1) % MOD;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_skip = 0; m_pc = 0; m_pe = 0; m_pd = 0;
        m_mis = 0; m_sticky = 0; m_wu = 0; m_wd = 0; m_err = 0;
    endtask

    task automatic compare_all();
        check("synced",     int'(ifc.synced),     int'(m_seen && !m_skip));
        check("expected",   int'(ifc.expected),   m_seen ? predict(m_pc, m_pe, m_pd) : 0);
        check("mismatch",   int'(ifc.mismatch),   int'(m_mis));
        check("err_sticky", int'(ifc.err_sticky), int'(m_sticky));
        check("err_count",  int'(ifc.err_count),  m_err);
        check("wrap_up",    int'(ifc.wrap_up),    int'(m_wu));
        check("wrap_down",  int'(ifc.wrap_down),  int'(m_wd));
    endtask

    // One clock: drive the sample, let the edge happen, advance the model
    // with the same sample and compare every output.
    task automatic step(input bit en, input bit dir, input int cnt, input bit clr);
        int  want;
        bit  ev;
        ifc.enable      = en;
        ifc.countUpDown = dir;
        ifc.count       = WIDTH'(cnt);
        ifc.clear       = clr;
        @(posedge clk);
        #1;
        want = predict(m_pc, m_pe, m_pd);
        if (!m_seen)     ev = (cnt != 0);
        else if (m_skip) ev = 0;
        else             ev = (cnt != want);
        m_wu = m_seen && !m_skip && !ev && m_pe && m_pd && (m_pc == MOD - 1) && (cnt == 0);
        m_wd = m_seen && !m_skip && !ev && m_pe && !m_pd && (m_pc == 0) && (cnt == MOD - 1);
        if (!m_seen)     begin m_seen = 1; m_skip = 0; end
        else if (m_skip) m_skip = 0;
        else             m_skip = ev;
        if (clr) begin
            m_seen = 0; m_skip = 0; m_mis = 0; m_sticky = 0; m_err = 0;
            m_wu = 0; m_wd = 0;
        end else begin
            m_mis = ev;
            if (ev) begin
                m_sticky = 1;
                if (m_err < ERR_MAX) m_err++;
            end
        end
        m_pc = cnt; m_pe = en; m_pd = dir;
        compare_all();
    endtask

    // Asynchronous reset away from the clock edge; outputs must drop at once.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        check("rst synced",   int'(ifc.synced),     0);
        check("rst expected", int'(ifc.expected),   0);
        check("rst mismatch", int'(ifc.mismatch),   0);
        check("rst sticky",   int'(ifc.err_sticky), 0);
        check("rst errcnt",   int'(ifc.err_count),  0);
        check("rst wrapup",   int'(ifc.wrap_up),    0);
        check("rst wrapdn",   int'(ifc.wrap_down),  0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wu_seen;
        int wd_seen;
        int c;
        bit en, dir, clr, fault;
        int cnt;

        ifc.enable = 0; ifc.countUpDown = 0; ifc.count = '0; ifc.clear = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Free-running up count across one wrap.
        wu_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, i % MOD, 0);
            wu_seen += int'(ifc.wrap_up);
            if (i == 1) check("up synced 2nd edge", int'(ifc.synced), 1);
        end
        check("up wrap_up count", wu_seen, 1);
        check("up err_count", int'(ifc.err_count), 0);

        // Down count from zero wraps to max.
        step(0, 0, 0, 1);
        wd_seen = 0;
        step(1, 0, 0, 0);
        wd_seen += int'(ifc.wrap_down);
        step(1, 0, 15, 0);
        wd_seen += int'(ifc.wrap_down);
        step(1, 0, 14, 0);
        wd_seen += int'(ifc.wrap_down);
        check("down wrap_down count", wd_seen, 1);
        check("down mismatch", int'(ifc.mismatch), 0);

        // Stuck at 5 while 6,7,8 were due.
        step(0, 0, 0, 1);
        for (int i = 0; i <= 5; i++) step(1, 1, i, 0);
        check("stuck expected", int'(ifc.expected), 6);
        step(1, 1, 5, 0);
        check("stuck first mismatch", int'(ifc.mismatch), 1);
        step(1, 1, 5, 0);
        check("stuck resync no mismatch", int'(ifc.mismatch), 0);
        check("stuck resync expected", int'(ifc.expected), 6);
        step(1, 1, 5, 0);
        check("stuck second mismatch", int'(ifc.mismatch), 1);
        check("stuck err_count", int'(ifc.err_count), 2);
        check("stuck sticky", int'(ifc.err_sticky), 1);

        // Counter moves while disabled.
        step(0, 0, 0, 1);
        for (int i = 0; i <= 6; i++) step(1, 1, i, 0);
        step(0, 1, 7, 0);
        check("hold expected", int'(ifc.expected), 7);
        step(0, 1, 8, 0);
        check("hold mismatch", int'(ifc.mismatch), 1);
        check("hold err_count", int'(ifc.err_count), 1);

        // Saturation then clear.
        step(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(0, 0, i, 0);
        check("sat err_count", int'(ifc.err_count), 3);
        check("sat model", m_err, 3);
        step(0, 0, 0, 1);
        check("clear err_count", int'(ifc.err_count), 0);
        check("clear sticky", int'(ifc.err_sticky), 0);
        check("clear synced", int'(ifc.synced), 0);
        step(0, 0, 0, 0);
        check("clear resynced", int'(ifc.synced), 1);

        // Clear wins over a simultaneous mismatch.
        step(0, 0, 9, 0);
        step(0, 0, 4, 1);
        check("clear priority mismatch", int'(ifc.mismatch), 0);
        check("clear priority errcnt", int'(ifc.err_count), 0);

        // Reset mid-run, then a non-zero first sample.
        for (int i = 0; i < 5; i++) step(1, 1, i, 0);
        async_reset();
        step(1, 1, 3, 0);
        check("reset first mismatch", int'(ifc.mismatch), 1);
        check("reset err_count", int'(ifc.err_count), 1);

        // Randomized traffic with occasional faults, clears and resets.
        step(0, 0, 0, 1);
        c = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                c = 0;
            end
            en    = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1) != 0;
            clr   = ($urandom_range(0, 49) == 0);
            fault = ($urandom_range(0, 19) == 0);
            cnt   = fault ? int'($urandom_range(0, MOD - 1)) : c;
            step(en, dir, cnt, clr);
            c = predict(c, en, dir);
            if (clr) c = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_count_checker.md
Name: updown_count_checker

Overview:
- Passive in-fabric monitor for the up/down counter. It samples the counter's control inputs and its count output on the same clock and checks each transition against an internal reference model.
- Reports mismatches, a sticky error flag, a saturating error count and wrap-around events.
- Sits alongside the counter in both the test harness and the FPGA top level, with no feedback into the counter.

Parameters:
- WIDTH, 4, width of the observed count.
- ERR_CNT_W, 8, width of the saturating error counter.
- CHECK_RESET_VAL, 1, when 1 the first sample after reset or clear must equal 0.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; the same net that resets the counter.
- enable  in  1  counter enable as driven to the counter.
- countUpDown  in  1  direction as driven to the counter; 1 = up, 0 = down.
- count  in  WIDTH  counter output under observation.
- clear  in  1  synchronous clear of statistics and model.
- synced  out  1  model is tracking (state TRACK).
- expected  out  WIDTH  model's predicted value for the current sample.
- mismatch  out  1  one-cycle pulse on a detected error.
- err_sticky  out  1  set on the first mismatch; held until clear or reset.
- err_count  out  ERR_CNT_W  saturating mismatch count.
- wrap_up  out  1  one-cycle pulse on a verified max->0 transition.
- wrap_down  out  1  one-cycle pulse on a verified 0->max transition.

Behaviour:
- Reset (rst_n=0, asynchronous): state=UNSYNC; all outputs 0; internal prev_count/prev_en/prev_dir = 0.
- Counter model, applied at each edge k:
  - C(k+1) = C(k)+1 mod 2^WIDTH if en(k) and dir(k)=1.
  - C(k+1) = C(k)-1 mod 2^WIDTH if en(k) and dir(k)=0.
  - C(k+1) = C(k) otherwise.
- States: UNSYNC, TRACK, RESYNC.
  - UNSYNC, first edge after reset/clear:
    - If CHECK_RESET_VAL=1 and count != 0: mismatch event.
    - Load prev_* from inputs either way; go to TRACK.
  - TRACK, every edge: compare count against expected.
    - Equal: stay in TRACK.
    - Not equal: mismatch event; go to RESYNC.
  - RESYNC: one edge with no compare. Model is reloaded from the observed count and controls; go to TRACK.
- expected is combinational from the registered prev_*: prev_count ±1 or hold, per prev_en/prev_dir. It equals 0 while in UNSYNC.
- Mismatch event:
  - mismatch=1 in the cycle after the sampling edge (registered output).
  - err_sticky<=1.
  - err_count += 1, holding at 2^ERR_CNT_W-1.
- prev_* reload from the current inputs on every edge in every state, including on mismatch, so the model follows the observed counter after an error.
- wrap_up: asserted when TRACK sees a match with prev_en=1, prev_dir=1, prev_count=all-ones, count=0.
- wrap_down: asserted when TRACK sees a match with prev_en=1, prev_dir=0, prev_count=0, count=all-ones.
- Both wrap pulses are registered and last 1 cycle; they never assert on a mismatching sample.
- synced=1 only in TRACK.
- clear=1 at an edge:
  - err_sticky, err_count and all pulses go to 0; state goes to UNSYNC.
  - clear has priority over a simultaneous mismatch; that mismatch is dropped.
- Reset mid-operation discards all statistics immediately; no partial pulse.
- Direction change while enabled is legal. Each edge's step uses the dir sampled on the previous edge.

Decomposition:
- Shared package counters_pkg: state encoding localparams (UNSYNC=2'd0, TRACK=2'd1, RESYNC=2'd2) and a function next_count(val, en, dir), so the counter and the checker share one definition of the model.
- One sub-module: sat_counter, a saturating incrementer with sync clear, used for err_count.

Test Plan:
- Up count with WIDTH=4: reset, enable=1, up=1, counter free-running for 20 edges -> no mismatch; synced=1 from the 2nd edge; exactly one wrap_up at 15->0; err_count=0.
- Down count from 0: up=0 for 3 edges -> wrap_down pulses once at 0->15; count sequence 15,14 accepted; no mismatch.
- Stuck fault: counting up, force count to 5 for 3 edges where 6,7,8 were due.
  - mismatch at the 1st edge (expected=6), then RESYNC, then mismatch again at the next compared edge (expected=6).
  - Result: err_count=2, err_sticky=1.
- Hold violation: enable=0, count changes 7->8 -> mismatch with expected=7; err_count increments by 1.
- Saturation and clear:
  - ERR_CNT_W=2, inject 5 mismatches -> err_count=3.
  - Then clear=1 for 1 cycle -> err_count=0, err_sticky=0, synced=0, then synced=1 one edge later.
- Reset check: assert rst_n=0 mid-run -> all outputs 0 immediately; release with count forced to 3 and CHECK_RESET_VAL=1 -> mismatch on the first edge, err_count=1.
